line_fill_responder: RTL and testbench

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

---
 rtl/line_fill_responder_pkg.sv | 20 ++
 rtl/line_fill_responder_word_ram.sv | 24 ++
 rtl/line_fill_responder.sv | 107 ++++++++++
 tb/tb_line_fill_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_responder_pkg.sv
// Shared widths and FSM encoding for the instruction line-fill responder.
// Purely declarative; no logic and no latency of its own.
package line_fill_responder_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_W      = 16;
    localparam int LINE_W      = 64;
    localparam int LINE_ADDR_W = 6;
    localparam int WORD_ADDR_W = 8;
    localparam int RAM_DEPTH   = 1 << WORD_ADDR_W;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FETCH,
        ST_RESPOND
    } state_t;

endpackage

// File: rtl/line_fill_responder_word_ram.sv
// 256x16 instruction store: synchronous write, asynchronous read.
// Zero read latency; no backpressure. Contents are deliberately never reset.
module word_ram
    import line_fill_responder_pkg::*;
(
    input  logic                   clock,
    input  logic                   we_i,
    input  logic [WORD_ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0]      wdata_i,
    input  logic [WORD_ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0]      rdata_o
);

    logic [WORD_W-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/line_fill_responder.sv
// Serves 4-word instruction-cache line fills from word_ram; ready strobe WAIT_CYCLES+4 cycles after request.
// No backpressure: requests while busy are dropped, program loads only land in quiet IDLE.
module line_fill_responder
    import line_fill_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   memory_read_enable,
    input  logic [LINE_ADDR_W-1:0] memory_address,
    output logic                   memory_read_ready,
    output logic [LINE_W-1:0]      memory_data,
    input  logic                   load_enable,
    input  logic [WORD_ADDR_W-1:0] load_address,
    input  logic [WORD_W-1:0]      load_data,
    output logic                   load_accept
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    state_t                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] line_q, line_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]             word_idx_q, word_idx_d;
    logic [LINE_W-1:0]      buf_q, buf_d;
    logic                   accept_q;
    logic                   load_we;
    logic [WORD_W-1:0]      ram_rdata;

    // Loads collide with neither a fill in progress nor a request being sampled.
    assign load_we = reset && load_enable && !memory_read_enable && (state_q == ST_IDLE);

    word_ram u_word_ram (
        .clock   (clock),
        .we_i    (load_we),
        .waddr_i (load_address),
        .wdata_i (load_data),
        .raddr_i ({line_q, word_idx_q}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        wait_cnt_d = wait_cnt_q;
        word_idx_d = word_idx_q;
        buf_d      = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (memory_read_enable) begin
                    line_d     = memory_address;
                    word_idx_d = '0;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = HAS_WAIT ? ST_WAIT : ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_FETCH: begin
                buf_d[{word_idx_q, 4'b0000} +: WORD_W] = ram_rdata;
                if (word_idx_q == LAST_WORD) begin
                    state_d = ST_RESPOND;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            wait_cnt_q <= '0;
            word_idx_q <= '0;
            buf_q      <= '0;
            accept_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            wait_cnt_q <= wait_cnt_d;
            word_idx_q <= word_idx_d;
            buf_q      <= buf_d;
            accept_q   <= load_we;
        end
    end

    assign memory_read_ready = (state_q == ST_RESPOND);
    assign memory_data       = buf_q;
    assign load_accept       = accept_q;

endmodule

// File: tb/tb_line_fill_responder.sv
// Two responders (2 and 0 wait cycles) share stimulus; checked against a word-array model.
module tb_line_fill_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic        clock;
    logic        reset;
    logic        en_a, en_b;
    logic [5:0]  raddr;
    logic        lden;
    logic [7:0]  ldaddr;
    logic [15:0] lddata;
    logic        rdy_a, rdy_b, acc_a, acc_b;
    logic [63:0] dat_a, dat_b;

    line_fill_responder #(.WAIT_CYCLES(WAIT_A)) dut_a (
        .clock(clock), .reset(reset),
        .memory_read_enable(en_a), .memory_address(raddr),
        .memory_read_ready(rdy_a), .memory_data(dat_a),
        .load_enable(lden), .load_address(ldaddr), .load_data(lddata),
        .load_accept(acc_a)
    );

    line_fill_responder #(.WAIT_CYCLES(WAIT_B)) dut_b (
        .clock(clock), .reset(reset),
        .memory_read_enable(en_b), .memory_address(raddr),
        .memory_read_ready(rdy_b), .memory_data(dat_b),
        .load_enable(lden), .load_address(ldaddr), .load_data(lddata),
        .load_accept(acc_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] model_mem [256];
    int n_chk  = 0;
    int n_fail = 0;
    int lat_a, lat_b, cnt_a, cnt_b, acc_seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_line(input logic [5:0] l);
        int base;
        base = int'(l) * 4;
        return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
    endfunction

    // Caller sits just after a negedge; write lands at the next posedge.
    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        lden = 1'b1; ldaddr = a; lddata = d;
        @(negedge clock);
        lden = 1'b0;
        model_mem[a] = d;
        check_val("load_acc_a", acc_a, 1);
        check_val("load_acc_b", acc_b, 1);
    endtask

    // mask[1] -> dut_a, mask[0] -> dut_b. inj: window cycle at which a stray request
    // is pulsed; ldc: cycle of a load pulse (-1 = together with the request, -2 = none).
    task automatic do_req(input logic [5:0] line, input logic [1:0] mask,
                          input int inj, input int ldc, input int win);
        raddr = line; en_a = mask[1]; en_b = mask[0]; lden = (ldc == -1);
        lat_a = -1; lat_b = -1; cnt_a = 0; cnt_b = 0; acc_seen = 0;
        @(negedge clock);
        acc_seen += int'(acc_a) + int'(acc_b);
        for (int i = 1; i <= win; i++) begin
            en_a = (i - 1 == inj) && mask[1];
            en_b = (i - 1 == inj) && mask[0];
            if (i - 1 == inj) raddr = line ^ 6'h15;
            lden = (i - 1 == ldc);
            @(negedge clock);
            if (rdy_a) begin cnt_a++; if (lat_a < 0) lat_a = i; end
            if (rdy_b) begin cnt_b++; if (lat_b < 0) lat_b = i; end
            acc_seen += int'(acc_a) + int'(acc_b);
        end
        en_a = 1'b0; en_b = 1'b0; lden = 1'b0;
    endtask

    task automatic check_resp(input logic [1:0] mask, input logic [5:0] line);
        if (mask[1]) begin
            check_val("lat_a", 64'(lat_a), 64'(WAIT_A + 4));
            check_val("strobes_a", 64'(cnt_a), 1);
            check_val("line_a", dat_a, exp_line(line));
        end
        if (mask[0]) begin
            check_val("lat_b", 64'(lat_b), 64'(WAIT_B + 4));
            check_val("strobes_b", 64'(cnt_b), 1);
            check_val("line_b", dat_b, exp_line(line));
        end
    endtask

    logic [63:0] cline;
    int          ctag;
    int          rsel, rinj, nrdy;
    logic [5:0]  rline;

    initial begin
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0; raddr = '0;
        lden = 1'b0; ldaddr = '0; lddata = '0;
        repeat (3) @(negedge clock);
        check_val("rst_rdy_a", rdy_a, 0);
        check_val("rst_rdy_b", rdy_b, 0);
        check_val("rst_dat_a", dat_a, 0);
        check_val("rst_dat_b", dat_b, 0);
        check_val("rst_acc_a", acc_a, 0);
        check_val("rst_acc_b", acc_b, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int a = 0; a < 256; a++) begin
            logic [15:0] w;
            case (a)
                8:   w = 16'h1111;
                9:   w = 16'h2222;
                10:  w = 16'h3333;
                11:  w = 16'h4444;
                default: w = 16'($urandom);
            endcase
            load_word(8'(a), w);
        end
        @(negedge clock);
        check_val("acc_clear", acc_a, 0);

        do_req(6'd2, 2'b11, -1, -2, 10);
        check_resp(2'b11, 6'd2);
        check_val("line2_const", dat_a, 64'h4444_3333_2222_1111);

        do_req(6'd63, 2'b11, -1, -2, 10);
        check_resp(2'b11, 6'd63);
        check_val("line63_top", dat_b[63:48], model_mem[255]);

        // Stray request during FETCH must be dropped.
        do_req(6'd5, 2'b11, 3, -2, 12);
        check_resp(2'b11, 6'd5);

        // Request in RESPOND dropped; request in first IDLE after RESPOND served.
        do_req(6'd7, 2'b10, -1, -2, 6);
        check_resp(2'b10, 6'd7);
        do_req(6'd9, 2'b10, -1, -2, 10);
        check_val("respond_req_ignored", 64'(cnt_a), 0);
        check_val("respond_req_data", dat_a, exp_line(6'd7));
        do_req(6'd7, 2'b10, -1, -2, 6);
        @(negedge clock);
        do_req(6'd12, 2'b10, -1, -2, 10);
        check_resp(2'b10, 6'd12);

        // Loads colliding with WAIT/FETCH or a sampled request are dropped.
        ldaddr = 8'd40; lddata = ~model_mem[40];
        do_req(6'd20, 2'b11, -1, 0, 10);
        check_val("load_in_wait_acc", 64'(acc_seen), 0);
        check_resp(2'b11, 6'd20);
        ldaddr = 8'd41; lddata = ~model_mem[41];
        do_req(6'd21, 2'b11, -1, -1, 10);
        check_val("load_with_req_acc", 64'(acc_seen), 0);
        do_req(6'd10, 2'b11, -1, -2, 10);
        check_resp(2'b11, 6'd10);
        load_word(8'd40, 16'hBEEF);
        @(negedge clock);
        do_req(6'd10, 2'b11, -1, -2, 10);
        check_resp(2'b11, 6'd10);

        // Reset during FETCH k=2 of dut_a aborts the fill.
        raddr = 6'd30; en_a = 1'b1;
        @(negedge clock);
        en_a = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_val("abort_rdy", rdy_a, 0);
        check_val("abort_dat", dat_a, 0);
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            nrdy += int'(rdy_a);
        end
        check_val("abort_no_strobe", 64'(nrdy), 0);
        do_req(6'd30, 2'b10, -1, -2, 10);
        check_resp(2'b10, 6'd30);

        // Requests and loads during reset are ignored.
        reset = 1'b0; lden = 1'b1; ldaddr = 8'd44; lddata = ~model_mem[44];
        en_a = 1'b1; en_b = 1'b1; raddr = 6'd11;
        repeat (2) @(negedge clock);
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; lden = 1'b0;
        @(negedge clock);
        check_val("rst_load_acc", acc_a, 0);
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            nrdy += int'(rdy_a) + int'(rdy_b);
        end
        check_val("rst_req_no_strobe", 64'(nrdy), 0);
        do_req(6'd11, 2'b11, -1, -2, 10);
        check_resp(2'b11, 6'd11);

        for (int n = 0; n < 60; n++) begin
            rsel  = $urandom_range(0, 3);
            rline = 6'($urandom);
            rinj  = int'($urandom_range(0, 5)) - 1;
            case (rsel)
                0: begin
                    load_word(8'($urandom), 16'($urandom));
                    @(negedge clock);
                end
                1: begin
                    do_req(rline, 2'b11, rinj, -2, 10);
                    check_resp(2'b11, rline);
                end
                2: begin
                    ldaddr = 8'($urandom); lddata = 16'($urandom);
                    do_req(rline, 2'b11, -2, rinj, 10);
                    check_val("rand_load_drop", 64'(acc_seen), 0);
                    check_resp(2'b11, rline);
                end
                default: begin
                    do_req(rline, 2'b10, rinj, -2, 10);
                    check_resp(2'b10, rline);
                end
            endcase
        end

        // Single-line instruction cache walking addresses 0..255 through dut_a.
        ctag = -1;
        cline = '0;
        for (int a = 0; a < 256; a++) begin
            if (ctag != a / 4) begin
                do_req(6'(a / 4), 2'b10, -1, -2, 7);
                check_val("cache_fill_lat", 64'(lat_a), 64'(WAIT_A + 4));
                cline = dat_a;
                ctag  = a / 4;
            end
            check_val("cache_instr", 64'(cline[(a % 4) * 16 +: 16]), 64'(model_mem[a]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
